// File: rtl/ldpc_3gpp_enc_p3_core_buf_if.sv
// rtl/ldpc_3gpp_enc_p3_core_buf_if.sv - p2-to-p3 core parity buffer write/read bus
interface ldpc_3gpp_enc_p3_core_buf_if #(
    parameter int pDAT_W = 8
);
    logic                   iwrite4p1;
    logic                   iwstart4p1;
    logic [pDAT_W-1:0]      iwdat4p1;
    logic                   iwrite4p2;
    logic                   iwstart4p2;
    logic [2:0][pDAT_W-1:0] iwdat4p2;
    logic                   iwdone;
    logic                   iread;
    logic                   irstart;
    logic [1:0]             irsel;
    logic                   irdone;
    logic                   oval;
    logic                   ostart;
    logic [pDAT_W-1:0]      odat;
    logic                   owfull;
    logic                   orempty;

    modport master (
        output iwrite4p1, iwstart4p1, iwdat4p1,
        output iwrite4p2, iwstart4p2, iwdat4p2, iwdone,
        output iread, irstart, irsel, irdone,
        input  oval, ostart, odat, owfull, orempty
    );

    modport slave (
        input  iwrite4p1, iwstart4p1, iwdat4p1,
        input  iwrite4p2, iwstart4p2, iwdat4p2, iwdone,
        input  iread, irstart, irsel, irdone,
        output oval, ostart, odat, owfull, orempty
    );
endinterface

// File: rtl/ldpc_3gpp_enc_p3_core_buf.sv
// rtl/ldpc_3gpp_enc_p3_core_buf.sv - ping-pong buffer for p1/p2 core parity columns
module ldpc_3gpp_enc_p3_core_buf #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iclkena,
    ldpc_3gpp_enc_p3_core_buf_if.slave bus
);
    localparam int cDEPTH = 1 << pADDR_W;

    typedef logic [pDAT_W-1:0]  dat_t;
    typedef logic [pADDR_W-1:0] addr_t;

    // bank x column x word; column 0 is p1, columns 1..3 are p2 rows 0..2
    dat_t  mem [2][4][cDEPTH];

    logic       wbank;
    logic       rbank;
    logic [1:0] full;
    logic [1:0] full_n;
    addr_t      wp1;
    addr_t      wp2;
    addr_t      rp;
    addr_t      waddr1;
    addr_t      waddr2;
    addr_t      raddr;
    logic       wfull;
    logic       rempty;
    logic       wr1_ok;
    logic       wr2_ok;
    logic       wdone_ok;
    logic       rdone_ok;

    // read pipeline: stage 1 is the RAM register, stage 2 the output register
    logic       rval1;
    logic       rstart1;
    dat_t       rdat1;
    logic       oval_q;
    logic       ostart_q;
    dat_t       odat_q;

    assign wfull  = full[0] & full[1];
    assign rempty = ~(full[0] | full[1]);

    assign bus.owfull  = wfull;
    assign bus.orempty = rempty;
    assign bus.oval    = oval_q;
    assign bus.ostart  = ostart_q;
    assign bus.odat    = odat_q;

    // addresses, write qualification and next bank-full state
    always_comb begin
        waddr1   = bus.iwstart4p1 ? '0 : wp1;
        waddr2   = bus.iwstart4p2 ? '0 : wp2;
        raddr    = bus.irstart    ? '0 : rp;
        wr1_ok   = bus.iwrite4p1 & ~wfull;
        wr2_ok   = bus.iwrite4p2 & ~wfull;
        wdone_ok = bus.iwdone & ~wfull;
        rdone_ok = bus.irdone & ~rempty;
        full_n   = full;
        // with one bank full, wbank and rbank differ, so both updates compose
        if (rdone_ok) full_n[rbank] = 1'b0;
        if (wdone_ok) full_n[wbank] = 1'b1;
    end

    // column write ports; contents are deliberately not reset
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (wr1_ok) mem[wbank][0][waddr1] <= bus.iwdat4p1;
            if (wr2_ok) begin
                mem[wbank][1][waddr2] <= bus.iwdat4p2[0];
                mem[wbank][2][waddr2] <= bus.iwdat4p2[1];
                mem[wbank][3][waddr2] <= bus.iwdat4p2[2];
            end
        end
    end

    // shared registered read port
    always_ff @(posedge iclk) begin
        if (iclkena && bus.iread) begin
            rdat1 <= mem[rbank][bus.irsel][raddr];
        end
    end

    // counters, bank flags and read valid/start pipeline
    always_ff @(posedge iclk) begin
        if (ireset) begin
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            full     <= 2'b00;
            wp1      <= '0;
            wp2      <= '0;
            rp       <= '0;
            rval1    <= 1'b0;
            rstart1  <= 1'b0;
            oval_q   <= 1'b0;
            ostart_q <= 1'b0;
            odat_q   <= '0;
        end else if (iclkena) begin
            if (bus.iwrite4p1) wp1 <= waddr1 + 1'b1;
            if (bus.iwrite4p2) wp2 <= waddr2 + 1'b1;
            // the read address advances even when the buffer is empty
            if (bus.iread)     rp  <= raddr + 1'b1;
            full <= full_n;
            if (wdone_ok) wbank <= ~wbank;
            if (rdone_ok) rbank <= ~rbank;
            rval1    <= bus.iread & ~rempty;
            rstart1  <= bus.iread & bus.irstart;
            oval_q   <= rval1;
            ostart_q <= rval1 & rstart1;
            if (rval1) odat_q <= rdat1;
        end
    end
endmodule

// File: tb/tb_ldpc_3gpp_enc_p3_core_buf.sv
// tb/tb_ldpc_3gpp_enc_p3_core_buf.sv - directed bench for the core parity ping-pong buffer
module tb_ldpc_3gpp_enc_p3_core_buf;
    logic iclk;
    logic ireset;
    logic iclkena;
    int   checks;
    int   errors;

    ldpc_3gpp_enc_p3_core_buf_if #(.pDAT_W(8)) bus ();

    ldpc_3gpp_enc_p3_core_buf #(.pADDR_W(2), .pDAT_W(8)) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .bus     (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iwrite4p1  = 1'b0;
        bus.iwstart4p1 = 1'b0;
        bus.iwdat4p1   = '0;
        bus.iwrite4p2  = 1'b0;
        bus.iwstart4p2 = 1'b0;
        bus.iwdat4p2   = '0;
        bus.iwdone     = 1'b0;
        bus.iread      = 1'b0;
        bus.irstart    = 1'b0;
        bus.irsel      = 2'd0;
        bus.irdone     = 1'b0;
    endtask

    // p1 word = p1base+a; p2 rows = p2base+a, p2base+0x10+a, p2base+0x20+a
    task automatic wr_pass(input logic [7:0] p1base, input logic [7:0] p2base,
                           input bit do_p2, input int n, input bit use_start);
        for (int a = 0; a < n; a++) begin
            bus.iwrite4p1   = 1'b1;
            bus.iwstart4p1  = use_start && (a == 0);
            bus.iwdat4p1    = p1base + 8'(a);
            bus.iwrite4p2   = do_p2;
            bus.iwstart4p2  = use_start && (a == 0);
            bus.iwdat4p2[0] = p2base + 8'(a);
            bus.iwdat4p2[1] = p2base + 8'h10 + 8'(a);
            bus.iwdat4p2[2] = p2base + 8'h20 + 8'(a);
            tick();
        end
        idle_inputs();
    endtask

    task automatic pulse_done(input bit wd, input bit rd);
        bus.iwdone = wd;
        bus.irdone = rd;
        tick();
        bus.iwdone = 1'b0;
        bus.irdone = 1'b0;
    endtask

    // four reads from address 0; e[k] is the word expected at address k
    task automatic do_read(input string name, input logic [1:0] sel, input logic [3:0][7:0] e);
        for (int c = 0; c < 6; c++) begin
            bus.iread   = (c < 4);
            bus.irstart = (c == 0);
            bus.irsel   = sel;
            tick();
            if (c == 0) begin
                checks++;
                if (bus.oval !== 1'b0) begin
                    errors++;
                    $display("FAIL %s oval_early got %b want 0", name, bus.oval);
                end
            end else if (c <= 4) begin
                checks++;
                if (bus.oval !== 1'b1 || bus.odat !== e[c-1] || bus.ostart !== (c == 1)) begin
                    errors++;
                    $display("FAIL %s word%0d got oval=%b ostart=%b odat=%h want 1 %b %h",
                             name, c-1, bus.oval, bus.ostart, bus.odat, (c == 1), e[c-1]);
                end
            end else begin
                checks++;
                if (bus.oval !== 1'b0) begin
                    errors++;
                    $display("FAIL %s oval_tail got %b want 0", name, bus.oval);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        iclkena = 1'b1;
        ireset  = 1'b1;
        tick();
        tick();
        ireset = 1'b0;
        checks++;
        if (bus.oval !== 1'b0 || bus.ostart !== 1'b0 || bus.odat !== 8'h00 ||
            bus.owfull !== 1'b0 || bus.orempty !== 1'b1) begin
            errors++;
            $display("FAIL reset got oval=%b ostart=%b odat=%h owfull=%b orempty=%b want 0 0 00 0 1",
                     bus.oval, bus.ostart, bus.odat, bus.owfull, bus.orempty);
        end
    endtask

    task automatic test_basic();
        wr_pass(8'h10, 8'h20, 1'b1, 4, 1'b1);
        checks++;
        if (bus.orempty !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_done orempty got %b want 1", bus.orempty);
        end
        pulse_done(1'b1, 1'b0);
        checks++;
        if (bus.orempty !== 1'b0 || bus.owfull !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags got orempty=%b owfull=%b want 0 0", bus.orempty, bus.owfull);
        end
        do_read("basic_sel2", 2'd2, {8'h33, 8'h32, 8'h31, 8'h30});
        do_read("basic_sel1", 2'd1, {8'h23, 8'h22, 8'h21, 8'h20});
        pulse_done(1'b0, 1'b1);
        checks++;
        if (bus.orempty !== 1'b1) begin
            errors++;
            $display("FAIL basic_freed orempty got %b want 1", bus.orempty);
        end
    endtask

    task automatic test_multipass();
        wr_pass(8'h50, 8'h00, 1'b0, 4, 1'b1);
        wr_pass(8'h60, 8'h00, 1'b0, 4, 1'b1);
        wr_pass(8'hA0, 8'h00, 1'b0, 4, 1'b1);
        pulse_done(1'b1, 1'b0);
        do_read("multipass", 2'd0, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
        pulse_done(1'b0, 1'b1);
    endtask

    task automatic test_pingpong();
        wr_pass(8'hB0, 8'h00, 1'b0, 4, 1'b1);
        pulse_done(1'b1, 1'b0);
        wr_pass(8'hC0, 8'h00, 1'b0, 4, 1'b1);
        pulse_done(1'b1, 1'b0);
        checks++;
        if (bus.owfull !== 1'b1 || bus.orempty !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_full got owfull=%b orempty=%b want 1 0", bus.owfull, bus.orempty);
        end
        wr_pass(8'hD0, 8'h00, 1'b0, 4, 1'b1);
        pulse_done(1'b1, 1'b0);
        do_read("pingpong_blk1", 2'd0, {8'hB3, 8'hB2, 8'hB1, 8'hB0});
        pulse_done(1'b0, 1'b1);
        checks++;
        if (bus.owfull !== 1'b0 || bus.orempty !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_release got owfull=%b orempty=%b want 0 0", bus.owfull, bus.orempty);
        end
        do_read("pingpong_blk2", 2'd0, {8'hC3, 8'hC2, 8'hC1, 8'hC0});
        pulse_done(1'b0, 1'b1);
        checks++;
        if (bus.orempty !== 1'b1) begin
            errors++;
            $display("FAIL pingpong_drained orempty got %b want 1", bus.orempty);
        end
    endtask

    task automatic test_simul_done();
        wr_pass(8'hE0, 8'hF0, 1'b1, 4, 1'b1);
        pulse_done(1'b1, 1'b0);
        wr_pass(8'h70, 8'h00, 1'b0, 4, 1'b1);
        checks++;
        if (bus.owfull !== 1'b0 || bus.orempty !== 1'b0) begin
            errors++;
            $display("FAIL simul_before got owfull=%b orempty=%b want 0 0", bus.owfull, bus.orempty);
        end
        pulse_done(1'b1, 1'b1);
        checks++;
        if (bus.owfull !== 1'b0 || bus.orempty !== 1'b0) begin
            errors++;
            $display("FAIL simul_after got owfull=%b orempty=%b want 0 0", bus.owfull, bus.orempty);
        end
        do_read("simul_newblk", 2'd0, {8'h73, 8'h72, 8'h71, 8'h70});
        pulse_done(1'b0, 1'b1);
        checks++;
        if (bus.orempty !== 1'b1) begin
            errors++;
            $display("FAIL simul_drained orempty got %b want 1", bus.orempty);
        end
    endtask

    task automatic test_wrap_clkena();
        logic [8:0]      ce_tab;
        logic [8:0]      rd_tab;
        logic [8:0]      val_tab;
        logic [8:0]      st_tab;
        logic [8:0][7:0] dat_tab;
        wr_pass(8'h80, 8'h00, 1'b0, 6, 1'b0);
        pulse_done(1'b1, 1'b0);
        ce_tab  = 9'b110_0011_11 >> 1;
        ce_tab  = 9'b111100011;
        rd_tab  = 9'b001111111;
        val_tab = 9'b011111110;
        st_tab  = 9'b000011110;
        dat_tab = {8'h83, 8'h83, 8'h82, 8'h85, 8'h84, 8'h84, 8'h84, 8'h84, 8'h00};
        for (int c = 0; c < 9; c++) begin
            iclkena     = ce_tab[c];
            bus.iread   = rd_tab[c];
            bus.irstart = (c == 0);
            bus.irsel   = 2'd0;
            tick();
            checks++;
            if (bus.oval !== val_tab[c] || bus.ostart !== st_tab[c] ||
                (val_tab[c] && bus.odat !== dat_tab[c])) begin
                errors++;
                $display("FAIL wrap_ce cycle%0d got oval=%b ostart=%b odat=%h want %b %b %h",
                         c, bus.oval, bus.ostart, bus.odat, val_tab[c], st_tab[c], dat_tab[c]);
            end
        end
        iclkena = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.iread   = 1'b1;
        bus.irstart = 1'b1;
        bus.irsel   = 2'd0;
        tick();
        bus.irstart = 1'b0;
        tick();
        checks++;
        if (bus.oval !== 1'b1 || bus.odat !== 8'h84) begin
            errors++;
            $display("FAIL rstmid_pre got oval=%b odat=%h want 1 84", bus.oval, bus.odat);
        end
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        checks++;
        if (bus.oval !== 1'b0 || bus.odat !== 8'h00 || bus.ostart !== 1'b0 ||
            bus.orempty !== 1'b1 || bus.owfull !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_edge got oval=%b odat=%h ostart=%b orempty=%b owfull=%b want 0 00 0 1 0",
                     bus.oval, bus.odat, bus.ostart, bus.orempty, bus.owfull);
        end
        tick();
        checks++;
        if (bus.oval !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flush oval got %b want 0", bus.oval);
        end
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ireset  = 1'b1;
        iclkena = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_multipass();
        test_pingpong();
        test_simul_done();
        test_wrap_clkena();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
